// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax datapath stages.
package softmax_pkg;

    localparam int DEFAULT_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } ctrl_state_e;

    // Wide subtract is exact for dw <= 63; only the negative side can clamp.
    function automatic logic signed [63:0] sat_sub(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 dw
    );
        logic signed [63:0] d;
        logic signed [63:0] lo;
        d  = a - b;
        lo = -(64'sd1 <<< (dw - 1));
        return (d < lo) ? lo : d;
    endfunction

endpackage

// File: rtl/max_tracker.sv
// Registered running signed maximum; init loads, update keeps the larger.
module max_tracker
    import softmax_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_i,
    input  logic                 update_i,
    input  logic signed [DW-1:0] data_i,
    output logic signed [DW-1:0] max_o
);

    logic signed [DW-1:0] max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
        end else if (init_i) begin
            max_q <= data_i;
        end else if (update_i && (data_i > max_q)) begin
            max_q <= data_i;
        end
    end

    assign max_o = max_q;

endmodule

// File: rtl/softmax_fifo_ctrl.sv
// Two-pass softmax row sequencer: load row into fifo tracking max,
// then drain it emitting saturated x - max.
module softmax_fifo_ctrl
    import softmax_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int N  = 32,
    parameter int LW = $clog2(N) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LW-1:0]        vec_len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic signed [DW-1:0] max_out,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data,
    input  logic                 out_ready,
    output logic                 fifo_clr,
    output logic                 fifo_wr_en,
    output logic signed [DW-1:0] fifo_wdata,
    output logic                 fifo_rd_en,
    input  logic signed [DW-1:0] fifo_rdata,
    input  logic                 fifo_full,
    input  logic                 fifo_empty
);

    ctrl_state_e state_q, state_d;

    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] wr_cnt_q, wr_cnt_d;
    logic [LW-1:0] rd_cnt_q, rd_cnt_d;
    logic [LW-1:0] hs_cnt_q, hs_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic          err_q, err_d;
    logic          len_ok;

    logic signed [DW-1:0] max_q;
    logic signed [63:0]   diff64;

    assign len_ok = (vec_len != '0) && (vec_len <= LW'(N));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        hs_cnt_d    = hs_cnt_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        fifo_clr    = 1'b0;
        in_ready    = 1'b0;
        fifo_wr_en  = 1'b0;
        fifo_rd_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d       = vec_len;
                    wr_cnt_d    = '0;
                    rd_cnt_d    = '0;
                    hs_cnt_d    = '0;
                    out_valid_d = 1'b0;
                    err_d       = !len_ok;
                    fifo_clr    = len_ok;
                    state_d     = len_ok ? LOAD : DONE;
                end
            end
            LOAD: begin
                in_ready   = (wr_cnt_q < len_q) && !fifo_full;
                fifo_wr_en = in_valid && in_ready;
                if (fifo_wr_en) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_d == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                fifo_rd_en = (rd_cnt_q < len_q) && !fifo_empty
                           && (!out_valid_q || out_ready);
                if (fifo_rd_en) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (out_valid_q && out_ready) begin
                    hs_cnt_d = hs_cnt_q + 1'b1;
                end
                if (fifo_rd_en) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
                // Exit once the final handshake has been registered.
                if (hs_cnt_q == len_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            hs_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            hs_cnt_q    <= hs_cnt_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    max_tracker #(
        .DW(DW)
    ) u_max (
        .clk     (clk),
        .rst_n   (rst_n),
        .init_i  (fifo_wr_en && (wr_cnt_q == '0)),
        .update_i(fifo_wr_en && (wr_cnt_q != '0)),
        .data_i  (in_data),
        .max_o   (max_q)
    );

    // The fifo holds its read data, so the difference needs no register.
    assign diff64 = sat_sub(64'(fifo_rdata), 64'(max_q), DW);

    assign out_data   = DW'(diff64);
    assign out_valid  = out_valid_q;
    assign fifo_wdata = in_data;
    assign max_out    = max_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_softmax_fifo_ctrl.sv
// Directed table-driven bench for softmax_fifo_ctrl with a behavioural fifo.
module tb_softmax_fifo_ctrl;

    localparam int DW = 8;
    localparam int N  = 8;
    localparam int LW = 4;

    typedef struct packed {
        int              len;
        logic [0:7][7:0] din;
        logic [0:7][7:0] exp;
        logic [7:0]      vmask;
        logic [7:0]      rmask;
        logic [7:0]      emax;
        logic            eerr;
        int              lat;
        int              restart;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] vec_len;
    logic          busy, done, err;
    logic [DW-1:0] max_out;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          fifo_clr, fifo_wr_en, fifo_rd_en;
    logic [DW-1:0] fifo_wdata;
    logic [DW-1:0] f_rdata = '0;
    logic          fifo_full, fifo_empty;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    softmax_fifo_ctrl #(.DW(DW), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vec_len   (vec_len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .max_out   (max_out),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .fifo_clr  (fifo_clr),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wdata(fifo_wdata),
        .fifo_rd_en(fifo_rd_en),
        .fifo_rdata(f_rdata),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty)
    );

    // Behavioural fifo: registered read, sync clear only via fifo_clr.
    logic [DW-1:0] fmem [N];
    int wp = 0;
    int rp = 0;
    int cnt = 0;
    logic f_wr, f_rd;

    assign f_wr       = fifo_wr_en && (cnt < N);
    assign f_rd       = fifo_rd_en && (cnt > 0);
    assign fifo_full  = (cnt == N);
    assign fifo_empty = (cnt == 0);

    always @(posedge clk) begin
        if (fifo_clr) begin
            wp  <= 0;
            rp  <= 0;
            cnt <= 0;
        end else begin
            if (f_wr) begin
                fmem[wp] <= fifo_wdata;
                wp       <= (wp + 1) % N;
            end
            if (f_rd) begin
                f_rdata <= fmem[rp];
                rp      <= (rp + 1) % N;
            end
            cnt <= cnt + int'(f_wr) - int'(f_rd);
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        ncmp++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    task automatic run_row(input vec_t v, input string tag);
        logic [7:0] got [8];
        logic [7:0] held = '0;
        logic [7:0] mx = '0;
        int  idx = 0;
        int  oidx = 0;
        int  wrs = 0;
        int  viol = 0;
        int  done_c = -1;
        bit  stall = 1'b0;
        bit  err_s = 1'b0;
        bit  legal;
        legal = (v.len >= 1) && (v.len <= N);
        @(negedge clk);
        start     = 1'b1;
        vec_len   = LW'(v.len);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1 check({tag, ".clr"}, 32'(fifo_clr), 32'(legal));
        for (int c = 1; c < 80 && done_c < 0; c++) begin
            @(negedge clk);
            start     = (c == v.restart);
            vec_len   = (c == v.restart) ? LW'(2) : LW'(v.len);
            in_valid  = (idx < v.len) && (idx < N) && v.vmask[c % 8];
            in_data   = ((idx < v.len) && (idx < N)) ? v.din[idx] : 8'h00;
            out_ready = v.rmask[c % 8];
            #1;
            if (c == 1) check({tag, ".busy"}, 32'(busy), 32'd1);
            if (start) check({tag, ".restart_clr"}, 32'(fifo_clr), 32'd0);
            if (fifo_full && in_ready) viol++;
            if (stall && out_valid && (out_data !== held)) viol++;
            if (out_valid && !out_ready && fifo_rd_en) viol++;
            stall = out_valid && !out_ready;
            held  = out_data;
            if (fifo_wr_en) begin
                wrs++;
                if (fifo_wdata !== in_data) viol++;
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                if (oidx < 8) got[oidx] = out_data;
                oidx++;
            end
            if (done) begin
                done_c = c;
                err_s  = err;
                mx     = max_out;
            end
        end
        if (done_c < 0) begin
            check({tag, ".done_timeout"}, 32'd0, 32'd1);
        end else if (v.lat > 0) begin
            check({tag, ".done_lat"}, 32'(done_c), 32'(v.lat));
        end
        check({tag, ".err"}, 32'(err_s), 32'(v.eerr));
        check({tag, ".writes"}, 32'(wrs), legal ? 32'(v.len) : 32'd0);
        check({tag, ".proto"}, 32'(viol), 32'd0);
        if (!v.eerr) begin
            check({tag, ".nout"}, 32'(oidx), 32'(v.len));
            check({tag, ".max"}, 32'(mx), 32'(v.emax));
            for (int k = 0; k < v.len && k < oidx && k < 8; k++) begin
                check($sformatf("%s.out%0d", tag, k), 32'(got[k]),
                      32'(v.exp[k]));
            end
        end
        @(negedge clk);
        #1 check({tag, ".idle"}, 32'({busy, done}), 32'd0);
    endtask

    vec_t tbl [8];
    vec_t post;

    initial begin
        tbl[0] = '{len: 4,
                   din: {8'd5, -8'sd3, 8'd9, 8'd2, 32'd0},
                   exp: {-8'sd4, -8'sd12, 8'd0, -8'sd7, 32'd0},
                   vmask: 8'hFF, rmask: 8'hFF, emax: 8'd9,
                   eerr: 1'b0, lat: 11, restart: -1};
        tbl[1] = '{len: 3,
                   din: {8'd1, 8'd2, 8'd3, 40'd0},
                   exp: {-8'sd2, -8'sd1, 8'd0, 40'd0},
                   vmask: 8'hFF, rmask: 8'b1001_1001, emax: 8'd3,
                   eerr: 1'b0, lat: -1, restart: -1};
        tbl[2] = '{len: 2,
                   din: {8'd127, 8'h80, 48'd0},
                   exp: {8'd0, 8'h80, 48'd0},
                   vmask: 8'hFF, rmask: 8'hFF, emax: 8'd127,
                   eerr: 1'b0, lat: 7, restart: -1};
        tbl[3] = '{len: 0, din: 64'd0, exp: 64'd0,
                   vmask: 8'hFF, rmask: 8'hFF, emax: 8'd0,
                   eerr: 1'b1, lat: 1, restart: -1};
        tbl[4] = '{len: 8,
                   din: {-8'sd5, 8'd20, -8'sd100, 8'd7,
                         8'd64, 8'h80, 8'd3, 8'd63},
                   exp: {-8'sd69, -8'sd44, 8'h80, -8'sd57,
                         8'd0, 8'h80, -8'sd61, -8'sd1},
                   vmask: 8'b1011_0101, rmask: 8'hFF, emax: 8'd64,
                   eerr: 1'b0, lat: -1, restart: -1};
        tbl[5] = '{len: N + 1, din: 64'd0, exp: 64'd0,
                   vmask: 8'hFF, rmask: 8'hFF, emax: 8'd0,
                   eerr: 1'b1, lat: 1, restart: -1};
        tbl[6] = '{len: 5,
                   din: {-8'sd10, -8'sd20, -8'sd1, -8'sd50, -8'sd1, 24'd0},
                   exp: {-8'sd9, -8'sd19, 8'd0, -8'sd49, 8'd0, 24'd0},
                   vmask: 8'hFF, rmask: 8'hFF, emax: 8'hFF,
                   eerr: 1'b0, lat: 13, restart: -1};
        tbl[7] = '{len: 3,
                   din: {8'd4, 8'd4, -8'sd4, 40'd0},
                   exp: {8'd0, 8'd0, -8'sd8, 40'd0},
                   vmask: 8'hFF, rmask: 8'hFF, emax: 8'd4,
                   eerr: 1'b0, lat: 9, restart: 2};
        post   = '{len: 2,
                   din: {8'd10, 8'd30, 48'd0},
                   exp: {-8'sd20, 8'd0, 48'd0},
                   vmask: 8'hFF, rmask: 8'hFF, emax: 8'd30,
                   eerr: 1'b0, lat: 7, restart: -1};

        rst_n     = 1'b0;
        start     = 1'b0;
        vec_len   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #3;
        check("reset.ctrl", 32'({busy, done, err, out_valid, in_ready,
              fifo_wr_en, fifo_rd_en, fifo_clr}), 32'd0);
        check("reset.max", 32'(max_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_row(tbl[i], $sformatf("row%0d", i));
        end

        // Abort a row mid-drain with an asynchronous reset.
        @(negedge clk);
        start    = 1'b1;
        vec_len  = LW'(4);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int c = 0; c < 20 && !out_valid; c++) begin
            @(negedge clk);
            #1;
        end
        check("midrst.pre", 32'({busy, out_valid}), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.ctrl", 32'({busy, done, err, out_valid, in_ready,
              fifo_wr_en, fifo_rd_en, fifo_clr}), 32'd0);
        check("midrst.max", 32'(max_out), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        run_row(post, "post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/softmax_fifo_ctrl.md
# softmax_fifo_ctrl

Two-pass sequencer for one softmax row held in an external `fifo` instance.

- **Pass 1 (LOAD):** accepts `vec_len` input elements, writes each one into the fifo and tracks the running signed maximum.
- **Pass 2 (DRAIN):** reads the fifo back and emits `x - max`, saturated, to the downstream exp/accumulate stage.

The block sits between the input stream and the exp stage and owns every fifo control signal.

## Interface
Parameters:
- `DW`, 32: element width, two's-complement signed.
- `N`, 32: fifo depth and maximum row length; must match the attached fifo.
- `LW`, `$clog2(N)+1`: width of length and count fields.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a row; sampled only in IDLE.
- `vec_len` input LW: row length; sampled with `start`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at end of row or on error.
- `err` output 1: high with `done` when `vec_len` was illegal.
- `max_out` output DW: row maximum; valid from DRAIN until next `start`.
- `in_valid`, `in_data` input 1/DW, `in_ready` output 1: input stream.
- `out_valid` output 1, `out_data` output DW, `out_ready` input 1: output stream.
- `fifo_clr` output 1: synchronous clear to the fifo's `rst`.
- `fifo_wr_en` output 1, `fifo_wdata` output DW: fifo write side.
- `fifo_rd_en` output 1, `fifo_rdata` input DW: fifo read side (fifo has 1-cycle registered read).
- `fifo_full`, `fifo_empty` input 1: fifo status.

## Operation
- **States:** IDLE, LOAD, DRAIN, DONE.
- **IDLE → LOAD:** on `start` with 1 ≤ `vec_len` ≤ N. `fifo_clr` = `start` & IDLE (combinational, 1 cycle).
- **IDLE → DONE, illegal length:** on `start` with `vec_len` == 0 or > N. `err` is set, and there are no transfers and no `fifo_clr`.
- **LOAD:**
  - `in_ready` = (`wr_cnt` < `len_q`) & !`fifo_full`.
  - `fifo_wr_en` = `in_valid` & `in_ready`; `fifo_wdata` = `in_data`.
  - The first accepted element loads `max_q`; each later one updates it with a signed `>` compare.
  - After the `len_q`-th write → DRAIN.
- **DRAIN:**
  - `fifo_rd_en` = (`rd_cnt` < `len_q`) & (!`out_valid` | `out_ready`) & !`fifo_empty`.
  - `out_valid` register: set the cycle after `fifo_rd_en`; cleared on an `out_ready` handshake with no new read.
  - `out_data` = sat(`fifo_rdata` - `max_q`), computed combinationally.
  - `out_data` needs no separate register, because the fifo holds `data_out` until the next read.
  - After the `len_q`-th output handshake → DONE.
- **DONE:** `done` = 1 for one cycle, then → IDLE. `err` clears on the next `start`.
- **Arithmetic:**
  - Subtract in DW+1 bits.
  - If the result is below -2^(DW-1), clamp to -2^(DW-1).
  - The result is always ≤ 0.
- **Simultaneous events:** `start` while busy is ignored. In DRAIN, `out_ready` and a new read in the same cycle keep `out_valid` high and advance the data.

## Timing
- **Reset values:** state = IDLE. `busy`, `done`, `err`, `out_valid`, `in_ready`, `fifo_wr_en`, `fifo_rd_en`, `fifo_clr` = 0. `max_out` = 0.
- **Reset mid-row:** returns to IDLE immediately. Stale fifo contents are flushed by the next `fifo_clr`.
- **Start latency:** `start` at cycle t → LOAD at t+1; the first `in_ready` is possible at t+1.
- **DRAIN latency:** the last input at cycle u → DRAIN at u+1, first `fifo_rd_en` at u+1, first `out_valid` at u+2.
- **Throughput:** with `in_valid` and `out_ready` held high, one element per cycle in each pass. A row of L elements gives `done` at t+2L+3.
- **`max_out`:** driven from `max_q` from DRAIN entry.

## Structure
- **Shared package `softmax_pkg`:**
  - `ctrl_state_e` enum.
  - `DW` default constant.
  - `sat_sub` function (DW+1-bit subtract with clamp).
- **Sub-module `max_tracker`:** registered running signed maximum with `init`/`update` inputs. Used here and reusable in later stages.
- The fifo itself is instantiated at the parent level, not inside this block.

## Test plan
- **Basic row:** `vec_len`=4, inputs 5, -3, 9, 2, `out_ready`=1 → `max_out`=9; outputs -4, -12, 0, -7; `done` at t+11; `err`=0.
- **Backpressure:** `vec_len`=3, inputs 1, 2, 3, `out_ready` toggles 1-0-0-1… → outputs -2, -1, 0 in order. `out_data` stays stable while `out_valid & !out_ready`, and no fifo read is issued in those cycles.
- **Saturation:** DW=8, inputs 127, -128 → outputs 0, -128 (clamped from -255).
- **Illegal lengths:** `vec_len`=0 → `done` and `err` at t+1, no `fifo_wr_en`. Same for `vec_len`=N+1.
- **Full row:** `vec_len`=N with a gappy `in_valid` → exactly N writes, `in_ready` never asserted while `fifo_full`, N outputs.
- **Reset and ignored start:** `rst_n` low mid-DRAIN → all outputs 0 asynchronously. After release, a new `start` pulses `fifo_clr` and the next row is correct. `start` asserted during LOAD is ignored.
